// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA raster timing generator with a frame-aligned test-pattern scheduler.
// All outputs are registered and decoded from the next raster position, so they never skew.
module vga_timing_ctrl #(
   parameter int H_VISIBLE          = 640,
   parameter int H_FRONT            = 16,
   parameter int H_SYNC             = 96,
   parameter int H_BACK             = 48,
   parameter int V_VISIBLE          = 480,
   parameter int V_FRONT            = 10,
   parameter int V_SYNC             = 2,
   parameter int V_BACK             = 33,
   parameter int SYNC_POL           = 0,
   parameter int NUM_PATTERNS       = 4,
   parameter int FRAMES_PER_PATTERN = 60
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        pix_en_i,
   input  logic        hold_i,
   output logic [9:0]  column_o,
   output logic [9:0]  row_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        visible_o,
   output logic        frame_start_o,
   output logic [3:0]  pattern_o,
   output logic [15:0] frame_count_o
);

   localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0]  H_LAST   = 10'(HT - 1);
   localparam logic [9:0]  V_LAST   = 10'(VT - 1);
   localparam logic [9:0]  H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0]  V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0]  HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0]  HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0]  VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]  VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic        SYNC_ACT = 1'(SYNC_POL);
   localparam logic [3:0]  PAT_LAST = 4'(NUM_PATTERNS - 1);
   localparam logic [15:0] FPC_LAST = 16'(FRAMES_PER_PATTERN - 1);

   logic [9:0]  col_nxt;
   logic [9:0]  row_nxt;
   logic        frame_entry;
   logic [15:0] fpc;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      col_nxt = column_o + 10'd1;
      row_nxt = row_o;
      if (column_o == H_LAST) begin
         col_nxt = '0;
         row_nxt = (row_o == V_LAST) ? '0 : row_o + 10'd1;
      end
   end

   assign frame_entry = pix_en_i && (column_o == H_LAST) && (row_o == V_LAST);

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         column_o      <= H_LAST;
         row_o         <= V_LAST;
         hsync_o       <= ~SYNC_ACT;
         vsync_o       <= ~SYNC_ACT;
         visible_o     <= 1'b0;
         frame_start_o <= 1'b0;
         pattern_o     <= '0;
         frame_count_o <= '0;
         fpc           <= '0;
      end else begin
         // Strobe follows the entry edge only, independent of later pix_en_i.
         frame_start_o <= frame_entry;
         if (pix_en_i) begin
            column_o  <= col_nxt;
            row_o     <= row_nxt;
            visible_o <= (col_nxt < H_VIS) && (row_nxt < V_VIS);
            hsync_o   <= (col_nxt >= HS_FIRST && col_nxt <= HS_LAST) ? SYNC_ACT : ~SYNC_ACT;
            vsync_o   <= (row_nxt >= VS_FIRST && row_nxt <= VS_LAST) ? SYNC_ACT : ~SYNC_ACT;
         end
         if (frame_entry) begin
            frame_count_o <= frame_count_o + 16'd1;
            if (!hold_i) begin
               if (fpc == FPC_LAST) begin
                  fpc       <= '0;
                  pattern_o <= (pattern_o == PAT_LAST) ? '0 : pattern_o + 4'd1;
               end else begin
                  fpc <= fpc + 16'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl on a shrunken raster (15x10) so whole frames fit in a short run.
// A driver pushes per-cycle expectations; a monitor pops and compares one cycle after each edge.
module tb_vga_timing_ctrl;

   localparam int HT = 15;
   localparam int VT = 10;
   localparam int FRAME = HT * VT;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_en;
   logic        hold;
   logic [9:0]  column;
   logic [9:0]  row;
   logic        hsync, vsync, visible, frame_start;
   logic [3:0]  pattern;
   logic [15:0] frame_count;

   vga_timing_ctrl #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .SYNC_POL(0), .NUM_PATTERNS(3), .FRAMES_PER_PATTERN(2)
   ) dut (
      .clk_i(clk), .reset_i(reset), .pix_en_i(pix_en), .hold_i(hold),
      .column_o(column), .row_o(row), .hsync_o(hsync), .vsync_o(vsync),
      .visible_o(visible), .frame_start_o(frame_start),
      .pattern_o(pattern), .frame_count_o(frame_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  col;
      logic [9:0]  row;
      logic        hs, vs, vis, fs;
      logic [3:0]  pat;
      logic [15:0] fc;
   } exp_t;

   exp_t exp_q[$];
   exp_t m;
   int   n_en, entries;
   int   pat_tab[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   fs_cyc[$];
   int   phase = 0;
   int   hs_low = 0, vs_low = 0, vis_cnt = 0;
   logic [3:0] prev_pat = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m.col = 10'd14; m.row = 10'd9;
      m.hs = 1'b1; m.vs = 1'b1; m.vis = 1'b0; m.fs = 1'b0;
      m.pat = '0; m.fc = '0;
      n_en = 0; entries = 0;
   endtask

   // Expected state after the coming edge, derived from the linear count of enabled edges.
   task automatic step(input logic en, input logic h);
      int pos;
      @(negedge clk);
      pix_en = en;
      hold   = h;
      m.fs   = 1'b0;
      if (en) begin
         n_en++;
         pos   = (n_en - 1) % FRAME;
         m.col = 10'(pos % HT);
         m.row = 10'(pos / HT);
         if (pos == 0) begin
            entries++;
            m.fs = 1'b1;
            m.fc = m.fc + 16'd1;
            if (entries <= pat_tab.size()) m.pat = 4'(pat_tab[entries-1]);
         end
         m.vis = (m.col < 8) && (m.row < 6);
         m.hs  = !(m.col >= 10 && m.col <= 12);
         m.vs  = !(m.row >= 7 && m.row <= 8);
      end
      exp_q.push_back(m);
   endtask

   task automatic drain();
      step(1'b0, hold);
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      check("scoreboard_drain", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; pix_en = 1'b0; hold = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      exp_q.delete();
      fs_cyc.delete();
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (reset) begin
         prev_pat = pattern;
      end else begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("column", 32'(column), 32'(e.col));
            check("row", 32'(row), 32'(e.row));
            check("hsync", 32'(hsync), 32'(e.hs));
            check("vsync", 32'(vsync), 32'(e.vs));
            check("visible", 32'(visible), 32'(e.vis));
            check("frame_start", 32'(frame_start), 32'(e.fs));
            check("frame_count", 32'(frame_count), 32'(e.fc));
            check("pattern", 32'(pattern), 32'(e.pat));
         end
         if (pattern != prev_pat) check("pattern_change_at_origin", 32'({column, row}), 0);
         prev_pat = pattern;
         if (frame_start) fs_cyc.push_back(cyc);
         if (phase == 1 && frame_count == 16'd1) begin
            if (row == 10'd0 && !hsync) hs_low++;
            if (!vsync) vs_low++;
            if (visible) vis_cnt++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; pix_en = 1'b0; hold = 1'b0;
      model_reset();
      #12;
      check("reset_column", 32'(column), 14);
      check("reset_row", 32'(row), 9);
      check("reset_hsync", 32'(hsync), 1);
      check("reset_vsync", 32'(vsync), 1);
      check("reset_visible", 32'(visible), 0);
      check("reset_frame_start", 32'(frame_start), 0);
      check("reset_pattern", 32'(pattern), 0);
      check("reset_frame_count", 32'(frame_count), 0);

      // Continuous pixel enable over eight frames.
      do_reset();
      pat_tab = '{0, 1, 1, 2, 2, 0, 0, 1};
      phase = 1;
      for (int i = 0; i < 8 * FRAME; i++) step(1'b1, 1'b0);
      drain();
      phase = 0;
      check("phaseA_frame_starts", fs_cyc.size(), 8);
      if (fs_cyc.size() >= 2) check("phaseA_frame_period", fs_cyc[1] - fs_cyc[0], FRAME);
      check("hsync_low_clks_line0", hs_low, 3);
      check("vsync_low_clks_frame1", vs_low, 2 * HT);
      check("visible_clks_frame1", vis_cnt, 8 * 6);

      // Hold over frame entries 3..4, plus a mid-frame hold glitch in frame 1.
      do_reset();
      pat_tab = '{0, 1, 1, 1, 1, 2};
      for (int i = 0; i < 6 * FRAME; i++)
         step(1'b1, (entries == 2 || entries == 3) || (entries == 1 && (n_en % HT) == 7));
      drain();
      check("phaseB_frame_starts", fs_cyc.size(), 6);

      // Pixel enable every 4th clock.
      do_reset();
      pat_tab = '{0, 1};
      for (int i = 0; i < FRAME + 1; i++) begin
         step(1'b1, 1'b0);
         repeat (3) step(1'b0, 1'b0);
      end
      drain();
      check("phaseC_frame_starts", fs_cyc.size(), 2);
      if (fs_cyc.size() >= 2) check("phaseC_frame_period", fs_cyc[1] - fs_cyc[0], 4 * FRAME);

      // Asynchronous reset in mid-frame at column 5, row 3.
      do_reset();
      pat_tab = '{0, 1, 1};
      for (int i = 0; i < 3 * HT + 6; i++) step(1'b1, 1'b0);
      drain();
      check("pre_reset_column", 32'(column), 5);
      check("pre_reset_row", 32'(row), 3);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_reset_column", 32'(column), 14);
      check("async_reset_row", 32'(row), 9);
      check("async_reset_visible", 32'(visible), 0);
      check("async_reset_frame_count", 32'(frame_count), 0);
      check("async_reset_pattern", 32'(pattern), 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      exp_q.delete();
      step(1'b1, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
